// File: rtl/vec_pkg.sv
// Shared constants and types for the vector writeback path.
// Default geometry: 16 lanes of 32 bits, 4-bit register addresses.
package vec_pkg;
  localparam int LANES      = 16;
  localparam int DW         = 32;
  localparam int AW         = 4;
  localparam int BEAT_LANES = 4;

  typedef logic [LANES-1:0][DW-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAL = 2'd1,
    VEC  = 2'd2
  } wb_state_t;
endpackage

// File: rtl/wb_beat_mux.sv
// Combinational selector of one BEAT_LANES-wide beat out of a full lane vector.
// Zero latency, no flow control.
module wb_beat_mux #(
  parameter int LANES      = 16,
  parameter int DW         = 32,
  parameter int BEAT_LANES = 4,
  parameter int BW         = 2
) (
  input  logic [LANES-1:0][DW-1:0]  buf_i,
  input  logic [BW-1:0]             beat_i,
  output logic [BEAT_LANES*DW-1:0]  dat_o
);
  localparam int NB = LANES / BEAT_LANES;

  always_comb begin
    dat_o = '0;
    for (int b = 0; b < NB; b++) begin
      if (beat_i == BW'(b)) dat_o = buf_i[b*BEAT_LANES +: BEAT_LANES];
    end
  end
endmodule

// File: rtl/vec_writeback_unit.sv
// MEM/WB consumer: one-beat scalar writes, NB-beat vector drains; writes land the cycle after accept.
// in_ready drops while a vector drain is in progress and rises again on its final beat.
module vec_writeback_unit #(
  parameter int LANES      = vec_pkg::LANES,
  parameter int DW         = vec_pkg::DW,
  parameter int BEAT_LANES = vec_pkg::BEAT_LANES,
  parameter int AW         = vec_pkg::AW,
  localparam int NB        = LANES / BEAT_LANES,
  localparam int BW        = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DW-1:0]      ALUOutW,
  input  logic [LANES*DW-1:0]      ReadDataW,
  input  logic                     MemtoRegW,
  input  logic                     RegWriteW,
  input  logic [AW-1:0]            WA3W,
  input  logic                     v_s_w,
  output logic                     rf_swe,
  output logic [AW-1:0]            rf_saddr,
  output logic [DW-1:0]            rf_swdata,
  output logic                     rf_vwe,
  output logic [AW-1:0]            rf_vaddr,
  output logic [BW-1:0]            rf_vbeat,
  output logic [BEAT_LANES*DW-1:0] rf_vwdata,
  output logic                     wb_done,
  output logic                     busy
);
  import vec_pkg::*;

  typedef logic [LANES-1:0][DW-1:0] lanes_t;

  wb_state_t               state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  lanes_t                  buf_q, buf_d, sel;
  logic [AW-1:0]           waddr_q, waddr_d;
  logic                    nowrite_d;

  logic                    swe_q, swe_d, vwe_q, vwe_d, done_q, done_d;
  logic [AW-1:0]           saddr_q, saddr_d, vaddr_q, vaddr_d;
  logic [DW-1:0]           swdata_q, swdata_d;
  logic [BW-1:0]           vbeat_q, vbeat_d;
  logic [BEAT_LANES*DW-1:0] vwdata_q, vwdata_d, beat_dat;

  logic accept, last_beat;

  assign sel       = MemtoRegW ? ReadDataW : ALUOutW;
  assign last_beat = (state_q == VEC) && (beat_q == BW'(NB-1));
  assign in_ready  = !RST && ((state_q != VEC) || last_beat);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    buf_d     = buf_q;
    waddr_d   = waddr_q;
    nowrite_d = 1'b0;
    if (accept) begin
      buf_d   = sel;
      waddr_d = WA3W;
      beat_d  = '0;
      if (!RegWriteW) begin
        state_d   = IDLE;
        nowrite_d = 1'b1;
      end else if (!v_s_w) begin
        state_d = SCAL;
      end else begin
        state_d = VEC;
      end
    end else if ((state_q == VEC) && !last_beat) begin
      beat_d = beat_q + 1'b1;
    end else begin
      state_d = IDLE;
      beat_d  = '0;
    end
  end

  // Outputs are precomputed from next state so the rf_* ports come straight from flops.
  wb_beat_mux #(
    .LANES      (LANES),
    .DW         (DW),
    .BEAT_LANES (BEAT_LANES),
    .BW         (BW)
  ) u_beat_mux (
    .buf_i  (buf_d),
    .beat_i (beat_d),
    .dat_o  (beat_dat)
  );

  always_comb begin
    swe_d    = 1'b0;
    saddr_d  = '0;
    swdata_d = '0;
    vwe_d    = 1'b0;
    vaddr_d  = '0;
    vbeat_d  = '0;
    vwdata_d = '0;
    done_d   = nowrite_d;
    case (state_d)
      SCAL: begin
        swe_d    = 1'b1;
        saddr_d  = waddr_d;
        swdata_d = buf_d[0];
        done_d   = 1'b1;
      end
      VEC: begin
        vwe_d    = 1'b1;
        vaddr_d  = waddr_d;
        vbeat_d  = beat_d;
        vwdata_d = beat_dat;
        done_d   = (beat_d == BW'(NB-1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      buf_q    <= '0;
      waddr_q  <= '0;
      swe_q    <= 1'b0;
      saddr_q  <= '0;
      swdata_q <= '0;
      vwe_q    <= 1'b0;
      vaddr_q  <= '0;
      vbeat_q  <= '0;
      vwdata_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      buf_q    <= buf_d;
      waddr_q  <= waddr_d;
      swe_q    <= swe_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      vwe_q    <= vwe_d;
      vaddr_q  <= vaddr_d;
      vbeat_q  <= vbeat_d;
      vwdata_q <= vwdata_d;
      done_q   <= done_d;
    end
  end

  assign rf_swe    = swe_q;
  assign rf_saddr  = saddr_q;
  assign rf_swdata = swdata_q;
  assign rf_vwe    = vwe_q;
  assign rf_vaddr  = vaddr_q;
  assign rf_vbeat  = vbeat_q;
  assign rf_vwdata = vwdata_q;
  assign wb_done   = done_q;
endmodule

// File: tb/tb_vec_writeback_unit.sv
// Directed table-driven bench for vec_writeback_unit plus a back-to-back vector sequence.
module tb_vec_writeback_unit;
  logic         CLK = 1'b0;
  logic         RST, in_valid, in_ready;
  logic [511:0] ALUOutW, ReadDataW;
  logic         MemtoRegW, RegWriteW, v_s_w;
  logic [3:0]   WA3W;
  logic         rf_swe, rf_vwe, wb_done, busy;
  logic [3:0]   rf_saddr, rf_vaddr;
  logic [31:0]  rf_swdata;
  logic [1:0]   rf_vbeat;
  logic [127:0] rf_vwdata;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  vec_writeback_unit dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .MemtoRegW(MemtoRegW),
    .RegWriteW(RegWriteW), .WA3W(WA3W), .v_s_w(v_s_w),
    .rf_swe(rf_swe), .rf_saddr(rf_saddr), .rf_swdata(rf_swdata),
    .rf_vwe(rf_vwe), .rf_vaddr(rf_vaddr), .rf_vbeat(rf_vbeat),
    .rf_vwdata(rf_vwdata), .wb_done(wb_done), .busy(busy)
  );

  typedef struct {
    logic        rst, vld, mtr, rw, vs;
    logic [3:0]  wa;
    logic [31:0] alu_b, mem_b;
    logic        e_rdy, e_swe;
    logic [3:0]  e_saddr;
    logic [31:0] e_swd;
    logic        e_vwe;
    logic [3:0]  e_vaddr;
    logic [1:0]  e_vbeat;
    logic [31:0] e_vw0;
    logic        e_done, e_busy;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic rst, logic vld, logic mtr, logic rw, logic vs,
                              logic [3:0] wa, logic [31:0] alu_b, logic [31:0] mem_b,
                              logic e_rdy, logic e_swe, logic [3:0] e_saddr,
                              logic [31:0] e_swd, logic e_vwe, logic [3:0] e_vaddr,
                              logic [1:0] e_vbeat, logic [31:0] e_vw0,
                              logic e_done, logic e_busy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.mtr = mtr; v.rw = rw; v.vs = vs; v.wa = wa;
    v.alu_b = alu_b; v.mem_b = mem_b; v.e_rdy = e_rdy; v.e_swe = e_swe;
    v.e_saddr = e_saddr; v.e_swd = e_swd; v.e_vwe = e_vwe; v.e_vaddr = e_vaddr;
    v.e_vbeat = e_vbeat; v.e_vw0 = e_vw0; v.e_done = e_done; v.e_busy = e_busy;
    return v;
  endfunction

  function automatic logic [127:0] beat_of(logic [31:0] base);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = base + 32'(j);
    return r;
  endfunction

  task automatic drive(logic rst, logic vld, logic mtr, logic rw, logic vs,
                       logic [3:0] wa, logic [31:0] alu_b, logic [31:0] mem_b);
    RST = rst; in_valid = vld; MemtoRegW = mtr; RegWriteW = rw; v_s_w = vs; WA3W = wa;
    for (int i = 0; i < 16; i++) begin
      ALUOutW[i*32 +: 32]   = alu_b + 32'(i);
      ReadDataW[i*32 +: 32] = mem_b + 32'(i);
    end
  endtask

  task automatic chk(string name, int row, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h want %h", name, row, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    //                 rst vld mtr rw vs wa  alu            mem         | rdy swe sa  swd           vwe va  vb  vw0        done busy
    tbl[0]  = mk(1, 1, 0, 1, 1, 4'd0, 32'hDEADBEEF, 32'h100,  0, 0, 0, 0,            0, 0, 0, 0,         0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 1, 4'd0, 32'hDEADBEEF, 32'h100,  0, 0, 0, 0,            0, 0, 0, 0,         0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 4'd0, 32'h0,        32'h0,    1, 0, 0, 0,            0, 0, 0, 0,         0, 0);
    tbl[3]  = mk(0, 1, 0, 1, 0, 4'd3, 32'hDEADBEEF, 32'h100,  1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0,         1, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 4'd0, 32'h0,        32'h0,    1, 0, 0, 0,            0, 0, 0, 0,         0, 0);
    tbl[5]  = mk(0, 1, 1, 1, 1, 4'd7, 32'hDEADBEEF, 32'h100,  1, 0, 0, 0,            1, 7, 0, 32'h100,   0, 1);
    tbl[6]  = mk(0, 1, 0, 1, 0, 4'd5, 32'h55,       32'h300,  0, 0, 0, 0,            1, 7, 1, 32'h104,   0, 1);
    tbl[7]  = mk(0, 1, 0, 1, 0, 4'd5, 32'h55,       32'h300,  0, 0, 0, 0,            1, 7, 2, 32'h108,   0, 1);
    tbl[8]  = mk(0, 1, 0, 1, 0, 4'd5, 32'h55,       32'h300,  0, 0, 0, 0,            1, 7, 3, 32'h10C,   1, 1);
    tbl[9]  = mk(0, 1, 0, 1, 0, 4'd5, 32'h55,       32'h300,  1, 1, 5, 32'h55,       0, 0, 0, 0,         1, 1);
    tbl[10] = mk(0, 1, 1, 1, 0, 4'd6, 32'h66,       32'h300,  1, 1, 6, 32'h300,      0, 0, 0, 0,         1, 1);
    tbl[11] = mk(0, 1, 0, 0, 1, 4'd9, 32'h77,       32'h300,  1, 0, 0, 0,            0, 0, 0, 0,         1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 4'd0, 32'h0,        32'h0,    1, 0, 0, 0,            0, 0, 0, 0,         0, 0);
    tbl[13] = mk(0, 1, 0, 1, 1, 4'd2, 32'h2000,     32'h100,  1, 0, 0, 0,            1, 2, 0, 32'h2000,  0, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 4'd0, 32'h0,        32'h0,    0, 0, 0, 0,            1, 2, 1, 32'h2004,  0, 1);
    tbl[15] = mk(1, 0, 0, 0, 0, 4'd0, 32'h0,        32'h0,    0, 0, 0, 0,            0, 0, 0, 0,         0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 4'd0, 32'h0,        32'h0,    1, 0, 0, 0,            0, 0, 0, 0,         0, 0);

    drive(1, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0);

    for (int r = 0; r < 17; r++) begin
      @(negedge CLK);
      drive(tbl[r].rst, tbl[r].vld, tbl[r].mtr, tbl[r].rw, tbl[r].vs,
            tbl[r].wa, tbl[r].alu_b, tbl[r].mem_b);
      #1;
      chk("in_ready", r, 128'(in_ready), 128'(tbl[r].e_rdy));
      @(posedge CLK);
      #1;
      chk("rf_swe",    r, 128'(rf_swe),    128'(tbl[r].e_swe));
      chk("rf_saddr",  r, 128'(rf_saddr),  128'(tbl[r].e_saddr));
      chk("rf_swdata", r, 128'(rf_swdata), 128'(tbl[r].e_swd));
      chk("rf_vwe",    r, 128'(rf_vwe),    128'(tbl[r].e_vwe));
      chk("rf_vaddr",  r, 128'(rf_vaddr),  128'(tbl[r].e_vaddr));
      chk("rf_vbeat",  r, 128'(rf_vbeat),  128'(tbl[r].e_vbeat));
      chk("rf_vwdata", r, rf_vwdata, tbl[r].e_vwe ? beat_of(tbl[r].e_vw0) : 128'h0);
      chk("wb_done",   r, 128'(wb_done),   128'(tbl[r].e_done));
      chk("busy",      r, 128'(busy),      128'(tbl[r].e_busy));
      chk("we_excl",   r, 128'(rf_swe & rf_vwe), 128'h0);
    end

    // Two vector loads back to back: 8 contiguous beats, done on beats 3 and 7.
    @(negedge CLK);
    drive(0, 1, 1, 1, 1, 4'd4, 32'h0, 32'h400);
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK);
      #1;
      chk("b2b_vwe",   100 + i, 128'(rf_vwe), 128'h1);
      chk("b2b_vbeat", 100 + i, 128'(rf_vbeat), 128'(i % 4));
      chk("b2b_vaddr", 100 + i, 128'(rf_vaddr), (i < 4) ? 128'd4 : 128'd8);
      chk("b2b_vwdata", 100 + i, rf_vwdata,
          beat_of(((i < 4) ? 32'h400 : 32'h800) + 32'(4 * (i % 4))));
      chk("b2b_done",  100 + i, 128'(wb_done), 128'((i % 4) == 3));
      if (i == 0) drive(0, 1, 1, 1, 1, 4'd8, 32'h0, 32'h800);
      if (i == 4) in_valid = 1'b0;
    end
    @(posedge CLK);
    #1;
    chk("b2b_idle_vwe",  200, 128'(rf_vwe), 128'h0);
    chk("b2b_idle_busy", 200, 128'(busy),   128'h0);
    chk("b2b_idle_done", 200, 128'(wb_done), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
